// File: rtl/bus_source_arbiter_pkg.sv
// Shared constants for the bus source arbiter: LC-3 word width, datapath source
// indices and a clog2 helper that never returns zero.
package bus_pkg;

    localparam int LC3_WORD_W = 16;

    localparam int SRC_MARMUX = 0;
    localparam int SRC_PC     = 1;
    localparam int SRC_ALU    = 2;
    localparam int SRC_MDR    = 3;

    // An index field narrower than one bit is never useful, even for a single source.
    function automatic int safeClog2(input int n);
        int result;
        result = 0;
        while ((1 << result) < n) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_source_arbiter_gate_prio_encoder.sv
// Combinational priority encoder over the source gates: winning index plus
// flags for "any gate high" and "two or more gates high".
module gate_prio_encoder
    import bus_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int PRIO_HIGH = 0,
    parameter int IDX_W     = safeClog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] gate,
    output logic [IDX_W-1:0]   idx,
    output logic               any,
    output logic               multi
);

    // Ascending scan: the first hit wins for low priority, the last hit for high priority.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gate[i]) begin
                if (PRIO_HIGH != 0 || !any) begin
                    idx = IDX_W'(i);
                end
                if (any) begin
                    multi = 1'b1;
                end
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Registered single-driver system bus resolved from NUM_SRC gated sources.
// Define BUS_KEEPER_EN to hold bus_out/bus_owner when no source is gated.
module bus_source_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH     = LC3_WORD_W,
    parameter int NUM_SRC   = 4,
    parameter int PRIO_HIGH = 0,
    parameter int CNT_WIDTH = 8,
    parameter int IDX_W     = safeClog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]         src_gate,
    input  logic                       clr_contention,
    output logic [WIDTH-1:0]           bus_out,
    output logic                       bus_valid,
    output logic [IDX_W-1:0]           bus_owner,
    output logic                       contention,
    output logic                       contention_sticky,
    output logic [CNT_WIDTH-1:0]       contention_cnt
);

    logic [IDX_W-1:0] winIdx;
    logic             anyGate;
    logic             multiGate;
    logic [WIDTH-1:0] winData;

    gate_prio_encoder #(
        .NUM_SRC   (NUM_SRC),
        .PRIO_HIGH (PRIO_HIGH),
        .IDX_W     (IDX_W)
    ) prioEncoder (
        .gate  (src_gate),
        .idx   (winIdx),
        .any   (anyGate),
        .multi (multiGate)
    );

    assign winData = src_data[winIdx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out           <= '0;
            bus_valid         <= 1'b0;
            bus_owner         <= '0;
            contention        <= 1'b0;
            contention_sticky <= 1'b0;
            contention_cnt    <= '0;
        end else begin
            bus_valid  <= anyGate;
            contention <= multiGate;
            if (anyGate) begin
                bus_out   <= winData;
                bus_owner <= winIdx;
            end else begin
`ifdef BUS_KEEPER_EN
                bus_out   <= bus_out;
                bus_owner <= bus_owner;
`else
                bus_out   <= '0;
                bus_owner <= '0;
`endif
            end
            // A contention event in the same cycle as a clear restarts the count at one.
            if (multiGate) begin
                contention_sticky <= 1'b1;
                if (clr_contention) begin
                    contention_cnt <= CNT_WIDTH'(1);
                end else if (contention_cnt != '1) begin
                    contention_cnt <= contention_cnt + 1'b1;
                end
            end else if (clr_contention) begin
                contention_sticky <= 1'b0;
                contention_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed testbench for bus_source_arbiter: default build, a PRIO_HIGH=1 copy
// and a CNT_WIDTH=2 copy share the same stimulus.
module tb_bus_source_arbiter;

    logic        clk;
    logic        rst;
    logic [63:0] srcData;
    logic [3:0]  srcGate;
    logic        clrContention;

    logic [15:0] busOut;
    logic        busValid;
    logic [1:0]  busOwner;
    logic        contention;
    logic        sticky;
    logic [7:0]  cnt;

    logic [15:0] hiBusOut;
    logic        hiBusValid;
    logic [1:0]  hiBusOwner;
    logic        hiContention;
    logic        hiSticky;
    logic [7:0]  hiCnt;

    logic [15:0] satBusOut;
    logic        satBusValid;
    logic [1:0]  satBusOwner;
    logic        satContention;
    logic        satSticky;
    logic [1:0]  satCnt;

    int compared;
    int mismatched;

    bus_source_arbiter #(.WIDTH(16), .NUM_SRC(4), .PRIO_HIGH(0), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .src_data(srcData), .src_gate(srcGate),
        .clr_contention(clrContention), .bus_out(busOut), .bus_valid(busValid),
        .bus_owner(busOwner), .contention(contention),
        .contention_sticky(sticky), .contention_cnt(cnt)
    );

    bus_source_arbiter #(.WIDTH(16), .NUM_SRC(4), .PRIO_HIGH(1), .CNT_WIDTH(8)) dutHi (
        .clk(clk), .rst(rst), .src_data(srcData), .src_gate(srcGate),
        .clr_contention(clrContention), .bus_out(hiBusOut), .bus_valid(hiBusValid),
        .bus_owner(hiBusOwner), .contention(hiContention),
        .contention_sticky(hiSticky), .contention_cnt(hiCnt)
    );

    bus_source_arbiter #(.WIDTH(16), .NUM_SRC(4), .PRIO_HIGH(0), .CNT_WIDTH(2)) dutSat (
        .clk(clk), .rst(rst), .src_data(srcData), .src_gate(srcGate),
        .clr_contention(clrContention), .bus_out(satBusOut), .bus_valid(satBusValid),
        .bus_owner(satBusOwner), .contention(satContention),
        .contention_sticky(satSticky), .contention_cnt(satCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        srcGate       = 4'b0010;
        srcData       = '0;
        srcData[31:16] = 16'h1234;
        clrContention = 1'b0;
        step();
        step();
        compared++; if (busOut !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_bus actual=%h required=0000", busOut); end
        compared++; if (busValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid actual=%b required=0", busValid); end
        compared++; if (busOwner !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_owner actual=%0d required=0", busOwner); end
        compared++; if (contention !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_contention actual=%b required=0", contention); end
        compared++; if (sticky !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sticky actual=%b required=0", sticky); end
        compared++; if (cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_cnt actual=%0d required=0", cnt); end
        rst = 1'b0;
        step();
        compared++; if (busOut !== 16'h1234) begin mismatched++; $display("[TB] FAIL release_bus actual=%h required=1234", busOut); end
        compared++; if (busOwner !== 2'd1) begin mismatched++; $display("[TB] FAIL release_owner actual=%0d required=1", busOwner); end
        compared++; if (busValid !== 1'b1) begin mismatched++; $display("[TB] FAIL release_valid actual=%b required=1", busValid); end
    endtask

    task automatic test_single_and_idle();
        srcGate       = 4'b0001;
        srcData[15:0] = 16'h3000;
        step();
        compared++; if (busOut !== 16'h3000) begin mismatched++; $display("[TB] FAIL single_bus actual=%h required=3000", busOut); end
        compared++; if (busOwner !== 2'd0) begin mismatched++; $display("[TB] FAIL single_owner actual=%0d required=0", busOwner); end
        compared++; if (busValid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid actual=%b required=1", busValid); end
        compared++; if (contention !== 1'b0) begin mismatched++; $display("[TB] FAIL single_contention actual=%b required=0", contention); end
        srcGate = 4'b0000;
        step();
        compared++; if (busValid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_valid actual=%b required=0", busValid); end
`ifdef BUS_KEEPER_EN
        compared++; if (busOut !== 16'h3000) begin mismatched++; $display("[TB] FAIL idle_bus actual=%h required=3000", busOut); end
`else
        compared++; if (busOut !== 16'h0000) begin mismatched++; $display("[TB] FAIL idle_bus actual=%h required=0000", busOut); end
`endif
        compared++; if (busOwner !== 2'd0) begin mismatched++; $display("[TB] FAIL idle_owner actual=%0d required=0", busOwner); end
    endtask

    task automatic test_contention();
        srcGate        = 4'b1010;
        srcData[31:16] = 16'hAAAA;
        srcData[63:48] = 16'h5555;
        step();
        compared++; if (busOut !== 16'hAAAA) begin mismatched++; $display("[TB] FAIL lowprio_bus actual=%h required=aaaa", busOut); end
        compared++; if (busOwner !== 2'd1) begin mismatched++; $display("[TB] FAIL lowprio_owner actual=%0d required=1", busOwner); end
        compared++; if (hiBusOut !== 16'h5555) begin mismatched++; $display("[TB] FAIL highprio_bus actual=%h required=5555", hiBusOut); end
        compared++; if (hiBusOwner !== 2'd3) begin mismatched++; $display("[TB] FAIL highprio_owner actual=%0d required=3", hiBusOwner); end
        compared++; if (contention !== 1'b1 || hiContention !== 1'b1) begin mismatched++; $display("[TB] FAIL contention_pulse actual=%b/%b required=1/1", contention, hiContention); end
        compared++; if (sticky !== 1'b1 || hiSticky !== 1'b1) begin mismatched++; $display("[TB] FAIL contention_sticky actual=%b/%b required=1/1", sticky, hiSticky); end
        compared++; if (cnt !== 8'd1 || hiCnt !== 8'd1) begin mismatched++; $display("[TB] FAIL contention_cnt actual=%0d/%0d required=1/1", cnt, hiCnt); end
        srcGate = 4'b0000;
        step();
        compared++; if (contention !== 1'b0 || hiBusValid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_after_contention actual=%b/%b required=0/0", contention, hiBusValid); end
        compared++; if (hiSticky !== 1'b1) begin mismatched++; $display("[TB] FAIL sticky_hold actual=%b required=1", hiSticky); end
`ifdef BUS_KEEPER_EN
        compared++; if (hiBusOwner !== 2'd3) begin mismatched++; $display("[TB] FAIL keep_owner actual=%0d required=3", hiBusOwner); end
`else
        compared++; if (hiBusOwner !== 2'd0) begin mismatched++; $display("[TB] FAIL keep_owner actual=%0d required=0", hiBusOwner); end
`endif
        clrContention = 1'b1;
        step();
        clrContention = 1'b0;
        compared++; if (sticky !== 1'b0 || cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL clear_idle actual=%b/%0d required=0/0", sticky, cnt); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] expSat [5];
        expSat[0] = 2'd1; expSat[1] = 2'd2; expSat[2] = 2'd3; expSat[3] = 2'd3; expSat[4] = 2'd3;
        srcGate = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            step();
            compared++; if (satCnt !== expSat[i]) begin mismatched++; $display("[TB] FAIL sat_cnt[%0d] actual=%0d required=%0d", i, satCnt, expSat[i]); end
            compared++; if (satContention !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_pulse[%0d] actual=%b required=1", i, satContention); end
            compared++; if (cnt !== 8'(i + 1)) begin mismatched++; $display("[TB] FAIL wide_cnt[%0d] actual=%0d required=%0d", i, cnt, i + 1); end
        end
    endtask

    task automatic test_clear_collision();
        srcGate       = 4'b0011;
        clrContention = 1'b1;
        step();
        compared++; if (satCnt !== 2'd1 || satSticky !== 1'b1) begin mismatched++; $display("[TB] FAIL clr_collide actual=%0d/%b required=1/1", satCnt, satSticky); end
        compared++; if (cnt !== 8'd1) begin mismatched++; $display("[TB] FAIL clr_collide_wide actual=%0d required=1", cnt); end
        compared++; if (busOut !== 16'h3000 || busOwner !== 2'd0) begin mismatched++; $display("[TB] FAIL clr_collide_bus actual=%h/%0d required=3000/0", busOut, busOwner); end
        srcGate = 4'b0001;
        step();
        clrContention = 1'b0;
        srcGate       = 4'b0000;
        compared++; if (satCnt !== 2'd0 || satSticky !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_plain actual=%0d/%b required=0/0", satCnt, satSticky); end
        compared++; if (satContention !== 1'b0 || satBusValid !== 1'b1) begin mismatched++; $display("[TB] FAIL clr_plain_flags actual=%b/%b required=0/1", satContention, satBusValid); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_single_and_idle();
        test_contention();
        test_back_to_back();
        test_clear_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
